// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one of four byte streams packet-atomic access to a UART transmitter.
// Latency: request in IDLE -> grant next cycle -> tx_wr/ack the cycle after (2 cycles); peak 1 byte / 2 cycles.
// Backpressure: tx_busy stalls acceptance in READY; an owner idling TIMEOUT READY cycles is forcibly released.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] data,
    input  logic [3:0]  last,
    output logic [3:0]  ack,
    output logic [3:0]  grant,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        XMIT  = 2'd2
    } state_t;

    // Counter value seen on the last idle READY cycle before a forced release.
    // The counter is 16 bits wide, so TIMEOUT is expected to fit in 16 bits.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [3:0]  grant_q;
    logic [1:0]  idx_q;       // binary index of the current owner
    logic [1:0]  ptr_q;       // index of the last released owner
    logic [15:0] cnt_q;       // saturating count of idle READY cycles
    logic        last_q;      // end-of-packet flag captured with the accepted byte
    logic [3:0]  ack_q;
    logic [7:0]  tx_data_q;
    logic        tx_wr_q;
    logic        to_q;

    logic [1:0]  rr_idx_d;
    logic        rr_hit_d;
    logic        own_req_d;
    logic        own_last_d;
    logic [7:0]  own_dat_d;

    // Current owner's request lane; only meaningful while a grant is held.
    assign own_req_d  = req[idx_q];
    assign own_last_d = last[idx_q];
    assign own_dat_d  = data[{idx_q, 3'b000} +: 8];

    // Round-robin winner: first requester found scanning ptr+1, ptr+2, ptr+3, ptr.
    always_comb begin
        rr_hit_d = 1'b0;
        rr_idx_d = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!rr_hit_d && req[ptr_q + 2'(k)]) begin
                rr_hit_d = 1'b1;
                rr_idx_d = ptr_q + 2'(k);
            end
        end
    end

    // Arbitration FSM; every output is a register so the UART sees clean strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            idx_q     <= 2'd0;
            ptr_q     <= 2'd3;
            cnt_q     <= 16'd0;
            last_q    <= 1'b0;
            ack_q     <= 4'b0000;
            tx_data_q <= 8'd0;
            tx_wr_q   <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            ack_q   <= 4'b0000;
            tx_wr_q <= 1'b0;
            to_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    grant_q <= 4'b0000;
                    if (rr_hit_d) begin
                        grant_q <= 4'b0001 << rr_idx_d;
                        idx_q   <= rr_idx_d;
                        cnt_q   <= 16'd0;
                        state_q <= READY;
                    end
                end
                READY: begin
                    if (own_req_d) begin
                        // A busy UART holds the byte without aging the owner.
                        if (!tx_busy) begin
                            tx_data_q <= own_dat_d;
                            tx_wr_q   <= 1'b1;
                            ack_q     <= grant_q;
                            last_q    <= own_last_d;
                            cnt_q     <= 16'd0;
                            state_q   <= XMIT;
                        end
                    end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                        // Owner went quiet mid-packet: hand the channel back.
                        to_q    <= 1'b1;
                        ptr_q   <= idx_q;
                        grant_q <= 4'b0000;
                        state_q <= IDLE;
                    end else if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                XMIT: begin
                    if (last_q) begin
                        ptr_q   <= idx_q;
                        grant_q <= 4'b0000;
                        state_q <= IDLE;
                    end else begin
                        state_q <= READY;
                    end
                end
                default: begin
                    grant_q <= 4'b0000;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign tx_wr       = tx_wr_q;
    assign timeout_err = to_q;

    // Structural invariants: at most one owner, and every write acknowledges exactly its owner.
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_wr_has_ack:   assert property (@(posedge clk) disable iff (rst) tx_wr_q == (ack_q != 4'b0000));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester packet queues feed a driver and an expected-byte scoreboard.
// Latency: outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
// Backpressure: a UART model raises tx_busy after each write; directed phases can force tx_busy high.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data       (data),
        .last       (last),
        .ack        (ack),
        .grant      (grant),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_busy    (tx_busy),
        .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // {last, byte} entries: pend feeds the driver, exp_q is the scoreboard.
    logic [8:0] pend  [4][$];
    logic [8:0] exp_q [4][$];
    int  gap [4];
    int  gap_max = 0;
    int  busy_max = 0;
    int  busy_cnt = 0;
    bit  busy_force = 1'b0;
    bit  wr_prev = 1'b0;
    bit  to_allowed = 1'b0;
    int  owner_log[$];

    // Reference arbitration state, kept at packet level.
    logic [3:0] grant_prev = 4'b0;
    logic [3:0] req_prev = 4'b0;
    int  ptr_m = 3;
    int  owner = -1;
    bit  done_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [3:0] rr_pick(input int p, input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(p + k) % 4]) return 4'(1 << ((p + k) % 4));
        return 4'b0000;
    endfunction

    function automatic int idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++)
            if (g[i]) return i;
        return -1;
    endfunction

    task automatic push(input int r, input logic [7:0] b, input bit l);
        pend[r].push_back({l, b});
        exp_q[r].push_back({l, b});
    endtask

    function automatic int backlog();
        int n = 0;
        for (int i = 0; i < 4; i++) n += exp_q[i].size() + pend[i].size();
        return n;
    endfunction

    task automatic wait_drain(input int limit, input string name);
        int t = 0;
        while ((backlog() != 0 || grant != 4'b0) && t < limit) begin
            @(negedge clk);
            t++;
        end
        check(name, backlog() + ((grant != 4'b0) ? 1 : 0), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_grant(input logic [3:0] g, input int limit, input string name);
        int t = 0;
        while (grant !== g && t < limit) begin
            @(negedge clk);
            t++;
        end
        check(name, grant, g);
    endtask

    // Requester and UART-core model.
    initial begin
        logic [8:0] tmp;
        for (int i = 0; i < 4; i++) gap[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                req = 4'b0; last = 4'b0; busy_cnt = 0; wr_prev = 1'b0;
                for (int i = 0; i < 4; i++) gap[i] = 0;
                tx_busy = busy_force;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (ack[i] && pend[i].size() > 0) begin
                        tmp = pend[i].pop_front();
                        gap[i] = $urandom_range(gap_max, 0);
                    end
                    if (gap[i] > 0) begin
                        gap[i]--;
                        req[i] = 1'b0;
                    end else if (pend[i].size() > 0) begin
                        tmp = pend[i][0];
                        req[i] = 1'b1;
                        data[8*i +: 8] = tmp[7:0];
                        last[i] = tmp[8];
                    end else begin
                        req[i] = 1'b0;
                        last[i] = 1'b0;
                    end
                end
                if (wr_prev) busy_cnt = $urandom_range(busy_max, 0);
                tx_busy = busy_force || (busy_cnt != 0);
                if (busy_cnt > 0) busy_cnt--;
                wr_prev = tx_wr;
            end
        end
    end

    // Monitor: compares every cycle against the packet-level reference.
    initial begin
        int i;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                grant_prev = 4'b0; req_prev = req; ptr_m = 3; owner = -1; done_pend = 1'b0;
            end else begin
                if (grant_prev == 4'b0) begin
                    check("grant_pick", grant, rr_pick(ptr_m, req_prev));
                    if (grant != 4'b0) owner_log.push_back(idx_of(grant));
                end else if (grant != grant_prev) begin
                    check("grant_hold", grant, 4'b0);
                    check("release_cause", done_pend | timeout_err, 1);
                end
                if (grant == 4'b0) done_pend = 1'b0;
                if (!to_allowed) check("no_timeout", timeout_err, 0);
                if (timeout_err) begin
                    if (grant_prev != 4'b0) ptr_m = idx_of(grant_prev);
                    owner = -1;
                end
                check("ack_vs_wr", ack, tx_wr ? grant : 4'b0);
                if (tx_wr) begin
                    i = idx_of(grant);
                    if (i < 0 || exp_q[i].size() == 0) begin
                        check("tx_unexpected", tx_wr, 0);
                    end else begin
                        if (owner >= 0) check("pkt_atomic", i, owner);
                        e = exp_q[i].pop_front();
                        check("tx_data", tx_data, e[7:0]);
                        if (e[8]) begin
                            owner = -1; ptr_m = i; done_pend = 1'b1;
                        end else begin
                            owner = i;
                        end
                    end
                end
                grant_prev = grant;
                req_prev = req;
            end
        end
    end

    // Watchdog.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1);
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int k, bad_wr, bad_to, r, len;
        rst = 1'b1; req = 4'b0; data = 32'h0; last = 4'b0; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_grant", grant, 0);
        check("reset_ack", ack, 0);
        check("reset_tx_wr", tx_wr, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_timeout", timeout_err, 0);
        #1 rst = 1'b0;

        // Two requesters; lowest index after ptr=3 wins, write two cycles after request.
        @(negedge clk);
        push(1, 8'hA5, 1'b1);
        push(3, 8'h3C, 1'b1);
        @(negedge clk);
        check("r020_grant_pre", grant, 4'b0000);
        @(negedge clk);
        check("r020_grant", grant, 4'b0010);
        check("r020_wr_early", tx_wr, 0);
        @(negedge clk);
        check("r020_wr", tx_wr, 1);
        check("r020_ack", ack, 4'b0010);
        check("r020_data", tx_data, 8'hA5);
        wait_drain(200, "r020_drain");

        // Three-byte packet on requester 2 holds off requester 0.
        push(2, 8'h41, 1'b0);
        push(2, 8'h42, 1'b0);
        push(2, 8'h43, 1'b1);
        wait_grant(4'b0100, 50, "r021_grant2");
        push(0, 8'h10, 1'b1);
        wait_grant(4'b0001, 100, "r021_grant0");
        check("r021_req2_done", exp_q[2].size(), 0);
        wait_drain(200, "r021_drain");

        // Owner abandons its packet after one byte.
        to_allowed = 1'b1;
        push(1, 8'h51, 1'b0);
        push(2, 8'h62, 1'b1);
        k = 0;
        while (!(ack[1] && tx_wr) && k < 50) begin @(negedge clk); k++; end
        check("r023_first_ack", ack, 4'b0010);
        k = 0;
        while (k < 30) begin
            @(negedge clk);
            k++;
            if (timeout_err) break;
        end
        check("r023_timeout_delay", k, 9);
        check("r023_grant_cleared", grant, 4'b0000);
        @(negedge clk);
        check("r023_next_grant", grant, 4'b0100);
        wait_drain(200, "r023_drain");
        to_allowed = 1'b0;

        // UART held busy: owner waits without timing out.
        busy_force = 1'b1;
        push(0, 8'h24, 1'b1);
        bad_wr = 0; bad_to = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_wr) bad_wr++;
            if (timeout_err) bad_to++;
        end
        check("r024_no_wr", bad_wr, 0);
        check("r024_no_timeout", bad_to, 0);
        check("r024_grant_held", grant, 4'b0001);
        busy_force = 1'b0;
        @(negedge clk);
        check("r024_wr_wait", tx_wr, 0);
        @(negedge clk);
        check("r024_wr", tx_wr, 1);
        check("r024_data", tx_data, 8'h24);
        wait_drain(200, "r024_drain");

        // Reset during XMIT clears outputs at once; arbitration restarts.
        push(2, 8'h71, 1'b0);
        push(2, 8'h72, 1'b1);
        k = 0;
        while (!tx_wr && k < 50) begin @(negedge clk); k++; end
        check("r025_in_xmit", tx_wr, 1);
        #1 rst = 1'b1;
        #1;
        check("r025_wr_async", tx_wr, 0);
        check("r025_ack_async", ack, 0);
        check("r025_grant_async", grant, 0);
        for (int i = 0; i < 4; i++) begin
            pend[i].delete();
            exp_q[i].delete();
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        push(3, 8'h83, 1'b1);
        wait_grant(4'b1000, 10, "r025_grant3");
        wait_drain(200, "r025_drain");

        // All four requesting: rotation 0,1,2,3,0,...
        owner_log.delete();
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < 4; i++) push(i, 8'(8'h90 + rep * 4 + i), 1'b1);
        wait_drain(300, "r022_drain");
        check("r022_count", owner_log.size(), 8);
        for (int j = 0; j < owner_log.size() && j < 8; j++)
            check("r022_order", owner_log[j], j % 4);

        // Randomized traffic with requester gaps and UART busy time.
        gap_max = 4;
        busy_max = 3;
        for (int p = 0; p < 80; p++) begin
            r = $urandom_range(3, 0);
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
            repeat ($urandom_range(6, 0)) @(negedge clk);
        end
        wait_drain(20000, "random_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, meaning consecutive granted-but-idle READY cycles before forced release (0 = timeout disabled, 16-bit range).
REQ-002 SHALL have ports, in order:
  clk  in  1  single system clock, rising edge
  rst  in  1  asynchronous, active-high reset
  req  in  4  per-requester byte-valid request
  data  in  32  requester i byte on data[8i+7:8i]
  last  in  4  per-requester end-of-packet flag, qualifies the current byte
  ack  out  4  one-cycle pulse: byte of requester i accepted
  grant  out  4  one-hot current owner, 0 when idle
  tx_data  out  8  byte to UART core
  tx_wr  out  1  one-cycle write strobe to UART core
  tx_busy  in  1  UART core transmitting
  timeout_err  out  1  one-cycle pulse on forced release
REQ-003 SHALL require the UART core to sample tx_wr on the rising edge and assert tx_busy in the following cycle.
REQ-004 SHALL drive all outputs from registers.

Function
REQ-005 SHALL implement states IDLE, READY, XMIT.
REQ-006 IDLE: grant=0; if req!=0, SHALL set grant to the round-robin winner and enter READY next cycle.
REQ-007 Round-robin SHALL search indices ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is the last released owner.
REQ-008 READY: if req[g]=1 and tx_busy=0, SHALL latch tx_data=data[g], set tx_wr=1 and ack[g]=1 for exactly one cycle (the XMIT cycle), capture last[g], clear the idle counter, and enter XMIT.
REQ-009 READY with req[g]=1 and tx_busy=1 SHALL wait without counting idle cycles.
REQ-010 READY with req[g]=0 SHALL increment the idle counter; when TIMEOUT!=0 and the counter reaches TIMEOUT-1, it SHALL pulse timeout_err, set ptr=g, clear grant, and enter IDLE.
REQ-011 XMIT: if captured last=1, SHALL set ptr=g and enter IDLE, else re-enter READY; grant held throughout.
REQ-012 Grant SHALL never change between the first byte of a packet and the byte flagged last, except by timeout or reset.
REQ-013 Requester SHALL present next byte/last in the cycle after ack; arbiter ignores data[g] except in READY acceptance cycle.
REQ-014 Peak throughput SHALL be one byte per 2 cycles plus UART busy time; req-to-tx_wr latency from IDLE SHALL be 2 cycles with tx_busy=0.
REQ-015 Requests from non-owners SHALL be ignored (no ack) until the owner releases.
REQ-016 Simultaneous last-byte acceptance and new reqs: the new owner SHALL be chosen in IDLE of the next cycle using updated ptr.
REQ-017 Idle counter SHALL be 16 bits, saturating, and cleared on entering READY from IDLE.

Reset
REQ-018 On rst=1 (asynchronous), SHALL force state=IDLE, grant=0, ack=0, tx_wr=0, tx_data=0, timeout_err=0, counter=0, ptr=3 (first priority to requester 0).
REQ-019 Reset mid-packet SHALL drop tx_wr immediately with no further ack; after release, arbitration restarts from requester 0.

Verification
REQ-020 After reset, req=4'b1010 -> grant=4'b0010 next cycle; tx_wr/ack[1] 2 cycles after req; tx_data=data[15:8].
REQ-021 Three-byte packet on req[2] (0x41,0x42,0x43 with last on third), req[0] asserted throughout -> three tx_wr with 0x41,0x42,0x43, no ack[0] until grant[2] drops, then grant=4'b0001.
REQ-022 All four requesting single-byte packets repeatedly -> grant order 0,1,2,3,0,...
REQ-023 TIMEOUT=8, owner drops req mid-packet -> timeout_err pulses after 8 READY cycles, grant=0, next requester granted.
REQ-024 tx_busy held high 50 cycles while owner requesting -> no tx_wr, no timeout_err; byte sent in the cycle after tx_busy falls plus one.
REQ-025 rst asserted during XMIT -> tx_wr, ack, grant low asynchronously; after release, req=4'b1000 -> grant=4'b1000.
